td4_run_ctrl: RTL

//  Run/debug controller sequencing the TD4 4-bit core. Loads the 16x8 program memory from a

---
 rtl/td4_pkg.sv | 34 +++
 rtl/td4_tick_div.sv | 28 ++
 rtl/td4_run_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 run/debug controller: command opcodes, FSM states
// and the command record presented on the host port.
package td4_pkg;

  localparam int INSTR_W = 8;
  localparam int ADDR_W  = 4;
  localparam int OP_W    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_RUN    = 3'd2,
    OP_STEP   = 3'd3,
    OP_HALT   = 3'd4,
    OP_SETDIV = 3'd5,
    OP_SETBP  = 3'd6,
    OP_CRST   = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_CRST = 3'd4
  } state_e;

  typedef struct packed {
    cmd_op_e              op;
    logic [ADDR_W-1:0]    addr;
    logic [INSTR_W-1:0]   data;
  } cmd_t;

endpackage

// File: rtl/td4_tick_div.sv
// Slow-rate prescaler: counts 0..((div+1)<<DIV_SHIFT)-1 and flags the terminal value.
module td4_tick_div #(
  parameter int DIV_SHIFT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clr,
  input  logic [7:0] i_div,
  output logic       o_tick
);

  localparam int CW = 8 + DIV_SHIFT;
  // (div+1)<<S - 1 is just div in the upper bits with all-ones below
  localparam logic [CW-1:0] LOW_ONES = CW'((64'd1 << DIV_SHIFT) - 64'd1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_term;

  assign w_term = (CW'(i_div) << DIV_SHIFT) | LOW_ONES;
  assign o_tick = (r_cnt == w_term);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             r_cnt <= '0;
    else if (i_clr || o_tick) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/td4_run_ctrl.sv
// Run/debug controller for the TD4 core: program loader, HALT/RUN/STEP clock-enable
// sequencing at a slow tick rate, one IP breakpoint and a core-reset sequencer.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int         DIV_SHIFT  = 16,
  parameter int         RST_CYCLES = 4,
  parameter logic [7:0] DIV_INIT   = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [3:0]  i_cmd_addr,
  input  logic [7:0]  i_cmd_data,
  output logic        o_prog_we,
  output logic [3:0]  o_prog_addr,
  output logic [7:0]  o_prog_wdata,
  input  logic [3:0]  i_core_ip,
  output logic        o_core_en,
  output logic        o_core_rst_n,
  output logic [2:0]  o_state,
  output logic        o_bp_hit,
  output logic        o_cmd_err
);

  localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_e             r_state, w_next;
  logic [RCW-1:0]     r_rst_cnt;
  logic [7:0]         r_div;
  logic               r_bp_en;
  logic [ADDR_W-1:0]  r_bp_addr;
  logic               r_bp_hit;
  logic               r_cmd_err;
  logic               r_first;
  logic [ADDR_W-1:0]  r_prog_addr;
  logic [INSTR_W-1:0] r_prog_wdata;

  cmd_t w_cmd;
  logic w_xfer, w_in_run, w_tick, w_kill, w_tick_live, w_bp_stop, w_illegal, w_tick_clr;

  assign w_cmd    = cmd_t'({i_cmd_op, i_cmd_addr, i_cmd_data});
  assign w_xfer   = i_cmd_valid && o_cmd_ready;
  assign w_in_run = (r_state == ST_RUN);
  // A tick coinciding with HALT / CORE_RESET / SETDIV is dropped, never half-issued
  assign w_kill      = w_xfer && (w_cmd.op inside {OP_HALT, OP_CRST, OP_SETDIV});
  assign w_tick_live = w_in_run && w_tick && !w_kill;
  assign w_bp_stop   = w_tick_live && r_bp_en && !r_first && (i_core_ip == r_bp_addr);
  assign w_illegal   = w_in_run && w_xfer && (w_cmd.op inside {OP_LOAD, OP_STEP});
  assign w_tick_clr  = !w_in_run || (w_xfer && w_cmd.op == OP_SETDIV);

  td4_tick_div #(.DIV_SHIFT(DIV_SHIFT)) u_div (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_tick_clr),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  // Reset lands in CRST so the core is held for RST_CYCLES after release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_CRST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer) begin
        case (w_cmd.op)
          OP_LOAD: w_next = ST_LOAD;
          OP_RUN:  w_next = ST_RUN;
          OP_STEP: w_next = ST_STEP;
          OP_CRST: w_next = ST_CRST;
          default: w_next = ST_IDLE;
        endcase
      end
      ST_LOAD: w_next = ST_IDLE;
      ST_STEP: w_next = ST_IDLE;
      ST_RUN: begin
        if (w_xfer && w_cmd.op == OP_HALT)      w_next = ST_IDLE;
        else if (w_xfer && w_cmd.op == OP_CRST) w_next = ST_CRST;
        else if (w_bp_stop)                     w_next = ST_IDLE;
      end
      ST_CRST: if (r_rst_cnt == '0) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
    o_prog_we    = (r_state == ST_LOAD);
    o_core_en    = (r_state == ST_STEP) || (w_tick_live && !w_bp_stop);
    o_core_rst_n = (r_state != ST_CRST);
    o_state      = r_state;
    o_bp_hit     = r_bp_hit;
    o_cmd_err    = r_cmd_err;
    o_prog_addr  = r_prog_addr;
    o_prog_wdata = r_prog_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rst_cnt    <= RST_LAST;
      r_div        <= DIV_INIT;
      r_bp_en      <= 1'b0;
      r_bp_addr    <= '0;
      r_bp_hit     <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_first      <= 1'b1;
      r_prog_addr  <= '0;
      r_prog_wdata <= '0;
    end else begin
      // Held at the reload value outside CRST, so entry always starts a full hold
      if (r_state != ST_CRST)  r_rst_cnt <= RST_LAST;
      else if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - RCW'(1);

      if (w_xfer) begin
        case (w_cmd.op)
          OP_SETDIV: r_div <= w_cmd.data;
          OP_SETBP: begin
            r_bp_en   <= w_cmd.data[0];
            r_bp_addr <= w_cmd.addr;
          end
          OP_LOAD: if (r_state == ST_IDLE) begin
            r_prog_addr  <= w_cmd.addr;
            r_prog_wdata <= w_cmd.data;
          end
          default: ;
        endcase
      end

      if (w_xfer && (w_cmd.op inside {OP_RUN, OP_STEP})) r_bp_hit <= 1'b0;
      else if (w_bp_stop)                                r_bp_hit <= 1'b1;

      if (w_xfer && w_cmd.op == OP_CRST) r_cmd_err <= 1'b0;
      else if (w_illegal)                r_cmd_err <= 1'b1;

      // Breakpoint is skipped on the first tick so RUN can resume from a hit
      if (!w_in_run)        r_first <= 1'b1;
      else if (w_tick_live) r_first <= 1'b0;
    end
  end

endmodule
